// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared definitions for the single-port RAM arbiter: default geometry,
// FSM state encoding and the requester id type.
// Optional feature macro used by the arbiter files: RAM_ARBITER_RR_EN
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

   localparam int ADLINES_DEF   = 10;    // RAM address width
   localparam int DATALINES_DEF = 32;    // RAM data width
   localparam int RAMSIZE_DEF   = 1024;  // number of RAM words

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Requester id: 0 = instruction fetch, 1 = load/store.
   typedef logic port_id_t;

   localparam port_id_t PORT_FETCH = 1'b0;
   localparam port_id_t PORT_LS    = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// ---------------------------------------------------------------------------
// ram_arb_pick
// Combinational winner selection between the two requesters.
//   Default build        : fixed priority, load/store (port 1) beats fetch.
//   RAM_ARBITER_RR_EN    : round-robin, on a tie the port that was not
//                          granted last time wins.
// Ports:
//   req0, req1 : request lines from port 0 / port 1
//   last_gnt   : id of the previously granted port (ignored in fixed mode)
//   any_req    : at least one request is pending
//   win        : winning port id (only meaningful when any_req is high)
// ---------------------------------------------------------------------------
module ram_arb_pick
   import ram_arbiter_pkg::*;
(
   input  logic     req0,
   input  logic     req1,
   input  port_id_t last_gnt,
   output logic     any_req,
   output port_id_t win
);

   assign any_req = req0 | req1;

`ifdef RAM_ARBITER_RR_EN
   always_comb begin
      win = PORT_LS;
      if (req0 && req1) begin
         win = ~last_gnt;
      end else if (req0) begin
         win = PORT_FETCH;
      end
   end
`else
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;

   assign win = req1 ? PORT_LS : PORT_FETCH;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port RAM between instruction fetch (port 0) and
// load/store (port 1). One access is in flight at a time; the winner gets a
// one-cycle ack (plus err for an out-of-range address) and, for reads, the
// data in its own rdata register which holds until that port's next ack.
// Optional feature macro: RAM_ARBITER_RR_EN (round-robin on ties instead of
// fixed port-1 priority).
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   pN_req/addr/we/wdata    request from port N, held until pN_ack
//   pN_ack                  one-cycle completion pulse
//   pN_err                  with ack: address was out of range
//   pN_rdata                read data, valid with ack, held afterwards
//   ram_address             RAM word address
//   ram_data                shared bidirectional RAM data bus
//   ram_read                RAM read strobe (RAM drives the bus)
//   ram_write               RAM write strobe (arbiter drives the bus)
//   busy                    FSM is not IDLE
//   gnt_id                  port currently or last served
//
// Access timing after the IDLE grant edge:
//   write : ISSUE -> RESP           (ack 2 cycles after grant)
//   read  : ISSUE -> CAPTURE -> RESP (ack 3 cycles after grant)
//   error : RESP                    (ack 1 cycle after grant)
// ---------------------------------------------------------------------------
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADLINES   = ADLINES_DEF,
   parameter int DATALINES = DATALINES_DEF,
   parameter int RAMSIZE   = RAMSIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 p0_req,
   input  logic [ADLINES-1:0]   p0_addr,
   input  logic                 p0_we,
   input  logic [DATALINES-1:0] p0_wdata,
   output logic                 p0_ack,
   output logic                 p0_err,
   output logic [DATALINES-1:0] p0_rdata,

   input  logic                 p1_req,
   input  logic [ADLINES-1:0]   p1_addr,
   input  logic                 p1_we,
   input  logic [DATALINES-1:0] p1_wdata,
   output logic                 p1_ack,
   output logic                 p1_err,
   output logic [DATALINES-1:0] p1_rdata,

   output logic [ADLINES-1:0]   ram_address,
   inout  wire  [DATALINES-1:0] ram_data,
   output logic                 ram_read,
   output logic                 ram_write,

   output logic                 busy,
   output logic                 gnt_id
);

   state_t                state, state_nxt;

   // Latched request of the current winner.
   logic [ADLINES-1:0]    addr_q;
   logic [DATALINES-1:0]  wdata_q;
   logic                  we_q;
   logic                  err_q;
   port_id_t              win_q;

   logic [DATALINES-1:0]  rdata0_q, rdata1_q;

   port_id_t              last_gnt;
   logic                  any_req;
   port_id_t              pick_win;

   logic [ADLINES-1:0]    sel_addr;
   logic                  sel_we;
   logic [DATALINES-1:0]  sel_wdata;
   logic                  sel_oor;

   logic                  drive_bus;

   // -------------------------------------------------------------------
   // Winner selection
   // -------------------------------------------------------------------
   ram_arb_pick u_pick (
      .req0     (p0_req),
      .req1     (p1_req),
      .last_gnt (last_gnt),
      .any_req  (any_req),
      .win      (pick_win)
   );

   assign sel_addr  = (pick_win == PORT_LS) ? p1_addr  : p0_addr;
   assign sel_we    = (pick_win == PORT_LS) ? p1_we    : p0_we;
   assign sel_wdata = (pick_win == PORT_LS) ? p1_wdata : p0_wdata;

   // Zero-extend before comparing so RAMSIZE may exceed the address range.
   assign sel_oor   = (32'(sel_addr) >= RAMSIZE);

   // -------------------------------------------------------------------
   // State and request registers
   // -------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         win_q    <= PORT_FETCH;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && any_req) begin
            addr_q  <= sel_addr;
            we_q    <= sel_we;
            wdata_q <= sel_wdata;
            err_q   <= sel_oor;
            win_q   <= pick_win;
         end

         // The RAM drives the word it registered at the ISSUE edge.
         if (state == CAPTURE) begin
            if (win_q == PORT_LS) begin
               rdata1_q <= ram_data;
            end else begin
               rdata0_q <= ram_data;
            end
         end
      end
   end

`ifdef RAM_ARBITER_RR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_gnt <= PORT_FETCH;
      end else if (state == IDLE && any_req) begin
         last_gnt <= pick_win;
      end
   end
`else
   assign last_gnt = PORT_FETCH;
`endif

   // -------------------------------------------------------------------
   // Next state and RAM strobes
   // -------------------------------------------------------------------
   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      ram_read  = 1'b0;
      ram_write = 1'b0;
      drive_bus = 1'b0;

      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = sel_oor ? RESP : ISSUE;
            end
         end

         ISSUE: begin
            if (we_q) begin
               ram_write = 1'b1;
               drive_bus = 1'b1;
               state_nxt = RESP;
            end else begin
               // Bus stays released; the RAM registers the word this edge.
               state_nxt = CAPTURE;
            end
         end

         CAPTURE: begin
            ram_read  = 1'b1;
            state_nxt = RESP;
         end

         RESP: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign ram_data    = drive_bus ? wdata_q : {DATALINES{1'bz}};
   assign ram_address = addr_q;

   // -------------------------------------------------------------------
   // Requester responses
   // -------------------------------------------------------------------
   assign p0_ack   = (state == RESP) && (win_q == PORT_FETCH);
   assign p1_ack   = (state == RESP) && (win_q == PORT_LS);
   assign p0_err   = p0_ack && err_q;
   assign p1_err   = p1_ack && err_q;
   assign p0_rdata = rdata0_q;
   assign p1_rdata = rdata1_q;

   assign busy   = (state != IDLE);
   assign gnt_id = win_q;

   // The RAM and the arbiter must never drive the data bus together.
   a_bus_exclusive: assert property (@(posedge clk) !(ram_read && drive_bus));

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter with a behavioural single-port RAM and
// a scoreboard memory. Directed steps cover reset, latency, priority,
// out-of-range accesses and reset mid-read; a random phase follows.
// Honours RAM_ARBITER_RR_EN when building the expected grant order.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int RS = 1024;

`ifdef RAM_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          p0_req = 1'b0, p1_req = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic          p0_we = 1'b0, p1_we = 1'b0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic          p0_ack, p1_ack, p0_err, p1_err;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic [AW-1:0] ram_address;
   wire  [DW-1:0] ram_data;
   logic          ram_read, ram_write, busy, gnt_id;

   always #5 clk = ~clk;

   ram_arbiter #(.ADLINES(AW), .DATALINES(DW), .RAMSIZE(RS)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .ram_address(ram_address), .ram_data(ram_data),
      .ram_read(ram_read), .ram_write(ram_write),
      .busy(busy), .gnt_id(gnt_id)
   );

   // Initial contents shared by the RAM device and the scoreboard.
   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 1) return 32'h11;
      if (i == 2) return 32'h22;
      return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
   endfunction

   // External single-port RAM: registers the addressed word every edge,
   // drives it while ram_read is high, commits writes on ram_write.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] ram_rd_q = '0;

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = init_val(i);
   end

   always @(posedge clk) begin
      if (ram_write) mem[ram_address] <= ram_data;
      ram_rd_q <= mem[ram_address];
   end

   assign ram_data = ram_read ? ram_rd_q : {DW{1'bz}};

   a_strobes_exclusive: assert property (@(posedge clk) !(ram_read && ram_write));

   // Scoreboard.
   logic [DW-1:0] ref_mem [0:RS-1];
   logic [DW-1:0] exp_rd [2];
   int            exp_last;
   int            n_checks = 0;
   int            n_errs = 0;
   int            lat;
   bit            strobe;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected winner from the arbitration rule, not from DUT state.
   function automatic int model_pick(input bit r0, input bit r1);
      if (r0 && r1) return RR ? (exp_last == 1 ? 0 : 1) : 1;
      return r1 ? 1 : 0;
   endfunction

   task automatic drive(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 1) begin
         p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
      end else begin
         p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
      end
   endtask

   // Waits (bounded) for the next ack; checks it went to port p.
   task automatic wait_ack(input int p, input bit drop, output int l, output bit s);
      l = 0;
      s = 1'b0;
      for (int i = 1; i <= 20 && l == 0; i++) begin
         @(negedge clk);
         if (ram_read || ram_write) s = 1'b1;
         if (p0_ack || p1_ack) begin
            l = i;
            check("ack_port", 64'(p1_ack), 64'(p));
            check("gnt_id", 64'(gnt_id), 64'(p));
         end
      end
      if (l == 0) begin
         n_checks++;
         n_errs++;
         $error("FAIL ack_timeout: observed=no ack for port %0d expected=ack within 20 cycles", p);
      end
      if (drop) begin
         if (p == 1) p1_req = 1'b0; else p0_req = 1'b0;
      end
   endtask

   // Applies the scoreboard effect of a completed access and checks data.
   task automatic retire(input int p, input logic we, input logic [AW-1:0] a);
      bit oor;
      oor = (int'(a) >= RS);
      check("err", 64'(p == 1 ? p1_err : p0_err), 64'(oor));
      if (!oor) begin
         if (we) ref_mem[a[9:0]] = (p == 1) ? p1_wdata : p0_wdata;
         else    exp_rd[p] = ref_mem[a[9:0]];
      end
      check("rdata0", 64'(p0_rdata), 64'(exp_rd[0]));
      check("rdata1", 64'(p1_rdata), 64'(exp_rd[1]));
      exp_last = p;
   endtask

   // One isolated access from IDLE with a latency check; ends back in IDLE.
   task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int exp_lat);
      drive(p, we, a, d);
      wait_ack(p, 1'b1, lat, strobe);
      check("latency", 64'(lat), 64'(exp_lat));
      retire(p, we, a);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=simulation still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   bit            pend [2];
   logic [AW-1:0] r_addr [2];
   logic          r_we [2];
   logic [DW-1:0] r_wd [2];
   int            age [2];

   initial begin
      for (int i = 0; i < RS; i++) ref_mem[i] = init_val(i);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_last  = 0;

      // Reset state.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 0);
      check("rst_ack", 64'({p0_ack, p1_ack, p0_err, p1_err}), 0);
      check("rst_strobes", 64'({ram_read, ram_write}), 0);
      check("rst_addr", 64'(ram_address), 0);
      check("rst_gnt", 64'(gnt_id), 0);
      check("rst_rdata0", 64'(p0_rdata), 0);
      check("rst_rdata1", 64'(p1_rdata), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // p1 write then p0 read-after-write of the same address.
      access(1, 1'b1, 11'd5, 32'hDEAD_BEEF, 2);
      access(0, 1'b0, 11'd5, 32'h0, 3);
      check("raw_data", 64'(p0_rdata), 64'h0000_0000_DEAD_BEEF);

      // Simultaneous reads of addresses 1 and 2.
      begin
         int w;
         drive(0, 1'b0, 11'd1, 32'h0);
         drive(1, 1'b0, 11'd2, 32'h0);
         w = model_pick(1'b1, 1'b1);
         wait_ack(w, 1'b1, lat, strobe);
         check("tie_lat_first", 64'(lat), 3);
         retire(w, 1'b0, (w == 1) ? 11'd2 : 11'd1);
         wait_ack(1 - w, 1'b1, lat, strobe);
         check("tie_lat_second", 64'(lat), 4);
         retire(1 - w, 1'b0, (w == 1) ? 11'd1 : 11'd2);
         check("tie_p0_data", 64'(p0_rdata), 64'h11);
         check("tie_p1_data", 64'(p1_rdata), 64'h22);
         @(negedge clk);
      end

      // Both requests held back-to-back for four accesses.
      drive(0, 1'b0, 11'd1, 32'h0);
      drive(1, 1'b0, 11'd2, 32'h0);
      for (int k = 0; k < 4; k++) begin
         int w;
         w = model_pick(1'b1, 1'b1);
         wait_ack(w, 1'b0, lat, strobe);
         check("held_lat", 64'(lat), (k == 0) ? 64'd3 : 64'd4);
         retire(w, 1'b0, (w == 1) ? 11'd2 : 11'd1);
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      @(negedge clk);

      // Out-of-range accesses: error after one cycle, RAM untouched.
      access(0, 1'b0, 11'd1024, 32'h0, 1);
      check("oor_rd_strobe", 64'(strobe), 0);
      access(1, 1'b1, 11'd1500, 32'hCAFE_F00D, 1);
      check("oor_wr_strobe", 64'(strobe), 0);
      access(1, 1'b0, 11'd1023, 32'h0, 3);

      // Reset while a p0 read is in CAPTURE, then the re-issued read.
      drive(0, 1'b0, 11'd7, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("capture_read", 64'(ram_read), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 0);
      check("midrst_ack", 64'(p0_ack), 0);
      check("midrst_bus", 64'({ram_read, ram_write}), 0);
      check("midrst_rdata", 64'(p0_rdata), 0);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_last  = 0;
      rst_n = 1'b1;
      wait_ack(0, 1'b1, lat, strobe);
      check("reissue_lat", 64'(lat), 3);
      retire(0, 1'b0, 11'd7);
      @(negedge clk);

      // Random traffic against the scoreboard.
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; age[p] = 0; r_addr[p] = '0; r_we[p] = 1'b0; r_wd[p] = '0;
      end
      for (int cyc = 0; cyc < 4300; cyc++) begin
         @(negedge clk);
         check("dual_ack", 64'(p0_ack & p1_ack), 0);
         for (int p = 0; p < 2; p++) begin
            if ((p == 1) ? p1_ack : p0_ack) begin
               check("rnd_pending", 64'(pend[p]), 1);
               check("rnd_gnt", 64'(gnt_id), 64'(p));
               retire(p, r_we[p], r_addr[p]);
               pend[p] = 1'b0;
            end else if (pend[p]) begin
               age[p]++;
               if (age[p] == 200) begin
                  n_checks++;
                  n_errs++;
                  $error("FAIL rnd_timeout: observed=no ack after 200 cycles on port %0d expected=ack", p);
               end
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && cyc < 4000 && $urandom_range(0, 1) == 1) begin
               pend[p]   = 1'b1;
               age[p]    = 0;
               r_we[p]   = 1'($urandom_range(0, 1));
               r_wd[p]   = $urandom;
               r_addr[p] = ($urandom_range(0, 4) != 0) ? AW'($urandom_range(0, 15))
                                                       : AW'($urandom_range(0, (1<<AW)-1));
            end
         end
         p0_req = pend[0]; p0_we = r_we[0]; p0_addr = r_addr[0]; p0_wdata = r_wd[0];
         p1_req = pend[1]; p1_we = r_we[1]; p1_addr = r_addr[1]; p1_wdata = r_wd[1];
      end
      check("drain0", 64'(pend[0]), 0);
      check("drain1", 64'(pend[1]), 0);
      check("final_busy", 64'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
